f2r_skew_feeder: RTL

F2R_SKEW_FEEDER -- requirements
Module: f2r_skew_feeder

---
 rtl/f2r_skew_feeder_pkg.sv | 26 ++
 rtl/f2r_skew_feeder_if.sv | 49 ++++
 rtl/f2r_skew_buffer.sv | 61 ++++++
 rtl/f2r_skew_feeder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/f2r_skew_feeder_pkg.sv
// ----------------------------------------------------------------------------
// f2r_skew_feeder_pkg
// Shared definitions for the F2R block family: the feeder state encoding,
// the packed per-port bus width helper and a counter width helper.
// No ports (package).
// ----------------------------------------------------------------------------
package f2r_skew_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_READY  = 2'd2,
        ST_STREAM = 2'd3
    } f2r_state_e;

    // Width of a packed bus carrying one element per port.
    function automatic int f2r_port_bus_w(input int data_size, input int num_port);
        return data_size * num_port;
    endfunction

    // Bits needed to index 0..n-1, never less than one bit.
    function automatic int f2r_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/f2r_skew_feeder_if.sv
// ----------------------------------------------------------------------------
// f2r_skew_feeder_if
// Bundles the parameter, stream-load, pass-control and systolic output
// signals of the skew feeder.
//   master : environment side (drives i_*, observes o_*)
//   slave  : feeder side (observes i_*, drives o_*)
// Signals:
//   i_set_param/i_num_row/i_row_len/i_reuse : parameter latch request
//   i_data/i_valid/o_ready                 : element load handshake
//   i_start/i_stall                        : pass control
//   o_loaded/o_done/o_param_err            : status
//   o_data/o_valid                         : skewed per-port outputs
// ----------------------------------------------------------------------------
interface f2r_skew_feeder_if #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_PORT  = 16
);
    import f2r_skew_feeder_pkg::*;

    localparam int BUS_W = f2r_port_bus_w(DATA_SIZE, NUM_PORT);

    logic                        i_set_param;
    logic [7:0]                  i_num_row;
    logic [7:0]                  i_row_len;
    logic                        i_reuse;
    logic signed [DATA_SIZE-1:0] i_data;
    logic                        i_valid;
    logic                        o_ready;
    logic                        i_start;
    logic                        i_stall;
    logic                        o_loaded;
    logic                        o_done;
    logic                        o_param_err;
    logic [BUS_W-1:0]            o_data;
    logic [NUM_PORT-1:0]         o_valid;

    modport master (
        output i_set_param, i_num_row, i_row_len, i_reuse,
        output i_data, i_valid, i_start, i_stall,
        input  o_ready, o_loaded, o_done, o_param_err, o_data, o_valid
    );

    modport slave (
        input  i_set_param, i_num_row, i_row_len, i_reuse,
        input  i_data, i_valid, i_start, i_stall,
        output o_ready, o_loaded, o_done, o_param_err, o_data, o_valid
    );

endinterface

// File: rtl/f2r_skew_buffer.sv
// ----------------------------------------------------------------------------
// f2r_skew_buffer
// NUM_PORT x MAX_DEPTH element store. Written row-major (row, column) one
// element per cycle; read combinationally as a skewed wavefront where port r
// presents column (t - r) of row r.
// Ports:
//   clk_i       : clock
//   we_i        : write enable
//   wr_row_i    : write row index
//   wr_col_i    : write column index
//   wdata_i     : element to write
//   rd_t_i      : wavefront time index
//   num_row_i   : active rows
//   row_len_i   : active elements per row
//   rd_data_o   : packed per-port elements (port r at [r*DATA_SIZE +: DATA_SIZE])
//   rd_valid_o  : per-port element valid
// ----------------------------------------------------------------------------
module f2r_skew_buffer
    import f2r_skew_feeder_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int NUM_PORT  = 16,
    parameter int MAX_DEPTH = 16
) (
    input  logic                                         clk_i,
    input  logic                                         we_i,
    input  logic [f2r_idx_w(NUM_PORT)-1:0]               wr_row_i,
    input  logic [f2r_idx_w(MAX_DEPTH)-1:0]              wr_col_i,
    input  logic signed [DATA_SIZE-1:0]                  wdata_i,
    input  logic [f2r_idx_w(MAX_DEPTH+NUM_PORT)-1:0]     rd_t_i,
    input  logic [f2r_idx_w(NUM_PORT+1)-1:0]             num_row_i,
    input  logic [f2r_idx_w(MAX_DEPTH+1)-1:0]            row_len_i,
    output logic [f2r_port_bus_w(DATA_SIZE,NUM_PORT)-1:0] rd_data_o,
    output logic [NUM_PORT-1:0]                          rd_valid_o
);

    localparam int CW = f2r_idx_w(MAX_DEPTH);

    // Storage is data only; contents are meaningless until a full load.
    logic signed [DATA_SIZE-1:0] mem_q [NUM_PORT][MAX_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_row_i][wr_col_i] <= wdata_i;
        end
    end

    // Port r is live while its column t-r lies inside the row.
    always_comb begin
        rd_data_o  = '0;
        rd_valid_o = '0;
        for (int r = 0; r < NUM_PORT; r++) begin
            if ((r < int'(num_row_i)) && (int'(rd_t_i) >= r) &&
                ((int'(rd_t_i) - r) < int'(row_len_i))) begin
                rd_valid_o[r] = 1'b1;
                rd_data_o[r*DATA_SIZE +: DATA_SIZE] = mem_q[r][CW'(int'(rd_t_i) - r)];
            end
        end
    end

endmodule

// File: rtl/f2r_skew_feeder.sv
// ----------------------------------------------------------------------------
// f2r_skew_feeder
// Loads a num_row x row_len block of signed elements from a stream, then
// replays it into a systolic array as a skewed wavefront: port r lags port
// r-1 by one cycle. Optionally keeps the block for repeated passes.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : f2r_skew_feeder_if.slave (parameters, load handshake, pass
//             control, status and skewed outputs)
// ----------------------------------------------------------------------------
module f2r_skew_feeder
    import f2r_skew_feeder_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int NUM_PORT  = 16,
    parameter int MAX_DEPTH = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    f2r_skew_feeder_if.slave   bus
);

    localparam int NRW   = f2r_idx_w(NUM_PORT + 1);
    localparam int RLW   = f2r_idx_w(MAX_DEPTH + 1);
    localparam int RW    = f2r_idx_w(NUM_PORT);
    localparam int CW    = f2r_idx_w(MAX_DEPTH);
    localparam int TW    = f2r_idx_w(MAX_DEPTH + NUM_PORT);
    localparam int BUS_W = f2r_port_bus_w(DATA_SIZE, NUM_PORT);

    f2r_state_e          state_q;
    logic [NRW-1:0]      num_row_q;
    logic [RLW-1:0]      row_len_q;
    logic                reuse_q;
    logic [CW-1:0]       col_q;
    logic [RW-1:0]       row_q;
    logic [TW-1:0]       t_q;
    logic [BUS_W-1:0]    data_q;
    logic [NUM_PORT-1:0] valid_q;
    logic                done_q;
    logic                perr_q;

    logic [CW-1:0]       col_d;
    logic [RW-1:0]       row_d;
    logic [TW-1:0]       t_d;
    logic                params_ok;
    logic                wr_en;
    logic                last_col;
    logic                last_row;
    logic                pass_end;
    logic [BUS_W-1:0]    rd_data;
    logic [NUM_PORT-1:0] rd_valid;

    assign params_ok = (bus.i_num_row != 8'd0) && (int'(bus.i_num_row) <= NUM_PORT) &&
                       (bus.i_row_len != 8'd0) && (int'(bus.i_row_len) <= MAX_DEPTH);
    assign wr_en     = (state_q == ST_LOAD) && bus.i_valid;
    assign last_col  = (int'(col_q) == int'(row_len_q) - 1);
    assign last_row  = (int'(row_q) == int'(num_row_q) - 1);
    // t runs 0..row_len+num_row-2 producing outputs; reaching the count
    // itself is the done cycle.
    assign pass_end  = (int'(t_q) == int'(row_len_q) + int'(num_row_q) - 1);
    assign col_d     = last_col ? '0 : col_q + 1'b1;
    assign row_d     = last_row ? '0 : row_q + 1'b1;
    assign t_d       = t_q + 1'b1;

    f2r_skew_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .NUM_PORT  (NUM_PORT),
        .MAX_DEPTH (MAX_DEPTH)
    ) u_buf (
        .clk_i      (i_clk),
        .we_i       (wr_en),
        .wr_row_i   (row_q),
        .wr_col_i   (col_q),
        .wdata_i    (bus.i_data),
        .rd_t_i     (t_q),
        .num_row_i  (num_row_q),
        .row_len_i  (row_len_q),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            num_row_q <= '0;
            row_len_q <= '0;
            reuse_q   <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            t_q       <= '0;
            data_q    <= '0;
            valid_q   <= '0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            perr_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_READY: begin
                    // A parameter request takes priority over a start.
                    if (bus.i_set_param) begin
                        if (params_ok) begin
                            num_row_q <= NRW'(bus.i_num_row);
                            row_len_q <= RLW'(bus.i_row_len);
                            reuse_q   <= bus.i_reuse;
                            col_q     <= '0;
                            row_q     <= '0;
                            state_q   <= ST_LOAD;
                        end else begin
                            perr_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else if ((state_q == ST_READY) && bus.i_start) begin
                        t_q     <= '0;
                        state_q <= ST_STREAM;
                    end
                end
                ST_LOAD: begin
                    if (wr_en) begin
                        col_q <= col_d;
                        if (last_col) begin
                            row_q <= row_d;
                            if (last_row) begin
                                state_q <= ST_READY;
                            end
                        end
                    end
                end
                ST_STREAM: begin
                    // Stall freezes t and the registered outputs, including
                    // the done cycle.
                    if (!bus.i_stall) begin
                        if (pass_end) begin
                            data_q  <= '0;
                            valid_q <= '0;
                            done_q  <= 1'b1;
                            t_q     <= '0;
                            state_q <= reuse_q ? ST_READY : ST_IDLE;
                        end else begin
                            data_q  <= rd_data;
                            valid_q <= rd_valid;
                            t_q     <= t_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_ready     = (state_q == ST_LOAD);
    assign bus.o_loaded    = (state_q == ST_READY);
    assign bus.o_done      = done_q;
    assign bus.o_param_err = perr_q;
    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;

endmodule
